// File: rtl/retire_trace_fifo.sv
// Retire-port to trace-checker buffer: filters records that do not write the
// register file, queues the rest in a fall-through FIFO, and tracks accepts and drops.
module retire_trace_fifo #(
   parameter int DEPTH     = 8,
   parameter int FILTER_X0 = 1,
   parameter int DROP_W    = 16
) (
   input  logic                     sys_clk,
   input  logic                     sys_reset_n,
   input  logic                     retire_valid,
   input  logic [69:0]              retire_record,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [69:0]              trace_record,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     fifo_full,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt,
   output logic [31:0]              accept_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [69:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_cnt;
   logic [31:0]       r_accept_cnt;

   logic w_elig;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_elig = retire_valid & retire_record[69] &
                   ((FILTER_X0 == 0) | (retire_record[68:64] != 5'd0));
   assign w_full = (r_count == CW'(DEPTH));
   assign w_pop  = (r_count != '0) & trace_ready;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign w_push = w_elig & (~w_full | w_pop);
   assign w_drop = w_elig & w_full & ~w_pop;

   always_ff @(posedge sys_clk) begin
      if (sys_reset_n && w_push) begin
         r_mem[r_wr_ptr] <= retire_record;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_reset_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_drop_cnt   <= '0;
         r_accept_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr     <= r_wr_ptr + AW'(1);
            r_accept_cnt <= r_accept_cnt + 32'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
               r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
         end
      end
   end

   assign trace_valid  = (r_count != '0);
   assign trace_record = r_mem[r_rd_ptr];
   assign fifo_count   = r_count;
   assign fifo_full    = w_full;
   assign overflow     = r_overflow;
   assign drop_cnt     = r_drop_cnt;
   assign accept_cnt   = r_accept_cnt;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Scoreboard bench for retire_trace_fifo: a queue holds the records expected at
// the head; counters and flags are modelled alongside it.
module tb_retire_trace_fifo;

   localparam int DEPTH = 8;

   logic                sys_clk = 1'b0;
   logic                sys_reset_n;
   logic                retire_valid;
   logic [69:0]         retire_record;
   logic                trace_valid;
   logic                trace_ready;
   logic [69:0]         trace_record;
   logic [3:0]          fifo_count;
   logic                fifo_full;
   logic                overflow;
   logic [15:0]         drop_cnt;
   logic [31:0]         accept_cnt;

   retire_trace_fifo #(.DEPTH(DEPTH), .FILTER_X0(1), .DROP_W(16)) dut (
      .sys_clk       (sys_clk),
      .sys_reset_n   (sys_reset_n),
      .retire_valid  (retire_valid),
      .retire_record (retire_record),
      .trace_valid   (trace_valid),
      .trace_ready   (trace_ready),
      .trace_record  (trace_record),
      .fifo_count    (fifo_count),
      .fifo_full     (fifo_full),
      .overflow      (overflow),
      .drop_cnt      (drop_cnt),
      .accept_cnt    (accept_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [69:0] sb [$];
   logic        m_ovf;
   logic [15:0] m_drop;
   logic [31:0] m_acc;

   task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [69:0] mk(input logic en, input logic [4:0] wa,
                                      input logic [31:0] wd, input logic [31:0] pc);
      return {en, wa, wd, pc};
   endfunction

   task automatic chk_state();
      chk("fifo_count", 70'(fifo_count), 70'(sb.size()));
      chk("fifo_full",  70'(fifo_full),  70'(sb.size() == DEPTH));
      chk("overflow",   70'(overflow),   70'(m_ovf));
      chk("drop_cnt",   70'(drop_cnt),   70'(m_drop));
      chk("accept_cnt", 70'(accept_cnt), 70'(m_acc));
   endtask

   // one clock: drive inputs, check the head against the scoreboard, update model
   task automatic cyc(input logic v, input logic [69:0] rec, input logic rdy);
      logic elig, full, pop, push, drop;
      retire_valid  = v;
      retire_record = rec;
      trace_ready   = rdy;
      #1;
      chk("trace_valid", 70'(trace_valid), 70'(sb.size() != 0));
      if (sb.size() != 0) chk("trace_record", trace_record, sb[0]);
      full = (sb.size() == DEPTH);
      pop  = (sb.size() != 0) && rdy;
      elig = v && rec[69] && (rec[68:64] != 5'd0);
      push = elig && (!full || pop);
      drop = elig && full && !pop;
      if (pop)  void'(sb.pop_front());
      if (push) begin sb.push_back(rec); m_acc++; end
      if (drop) begin
         m_ovf = 1'b1;
         if (m_drop != 16'hFFFF) m_drop++;
      end
      @(posedge sys_clk);
      #1;
      chk_state();
   endtask

   task automatic model_clear();
      sb.delete();
      m_ovf  = 1'b0;
      m_drop = '0;
      m_acc  = '0;
   endtask

   initial begin
      sys_reset_n   = 1'b0;
      retire_valid  = 1'b0;
      retire_record = '0;
      trace_ready   = 1'b0;
      model_clear();
      repeat (2) @(posedge sys_clk);
      #1;
      sys_reset_n = 1'b1;
      chk_state();
      chk("reset_valid", 70'(trace_valid), 70'(0));

      for (int i = 0; i < 3; i++)
         cyc(1'b1, mk(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 32'(4 * i)), 1'b1);
      repeat (3) cyc(1'b0, '0, 1'b1);
      chk("accept3", 70'(accept_cnt), 70'(3));
      chk("empty3",  70'(fifo_count), 70'(0));

      cyc(1'b1, mk(1'b0, 5'd7, 32'h1111, 32'h10), 1'b1);
      cyc(1'b1, mk(1'b1, 5'd0, 32'h2222, 32'h14), 1'b1);
      cyc(1'b0, mk(1'b1, 5'd9, 32'h3333, 32'h18), 1'b1);
      chk("filter_acc", 70'(accept_cnt), 70'(3));
      chk("filter_cnt", 70'(fifo_count), 70'(0));

      for (int i = 0; i < 10; i++)
         cyc(1'b1, mk(1'b1, 5'(i + 1), 32'hB000_0000 + 32'(i), 32'h20 + 32'(4 * i)), 1'b0);
      chk("full8",    70'(fifo_full), 70'(1));
      chk("ovf_set",  70'(overflow),  70'(1));
      chk("drop2",    70'(drop_cnt),  70'(2));

      cyc(1'b1, mk(1'b1, 5'd5, 32'hC0DE, 32'h100), 1'b1);
      chk("full_pp_cnt",  70'(fifo_count), 70'(8));
      chk("full_pp_drop", 70'(drop_cnt),   70'(2));
      repeat (10) cyc(1'b0, '0, 1'b1);

      cyc(1'b1, mk(1'b1, 5'd3, 32'hD1, 32'h200), 1'b0);
      cyc(1'b1, mk(1'b1, 5'd4, 32'hD2, 32'h204), 1'b0);
      repeat (5) cyc(1'b0, '0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1);

      for (int i = 0; i < 5; i++)
         cyc(1'b1, mk(1'b1, 5'(i + 1), 32'hE0 + 32'(i), 32'h300 + 32'(4 * i)), 1'b0);
      sys_reset_n   = 1'b0;
      retire_valid  = 1'b1;
      retire_record = mk(1'b1, 5'd6, 32'hEE, 32'h400);
      trace_ready   = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_reset_n  = 1'b1;
      retire_valid = 1'b0;
      model_clear();
      chk_state();
      chk("rst_valid", 70'(trace_valid), 70'(0));

      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 3) != 0),
             mk(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)),
                $urandom, 32'(i * 4)),
             ($urandom_range(0, 2) == 0));
      repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Synthesizable buffer between the CPU retire port and the simulation trace checker.
- Accepts one 70-bit retire record per cycle and filters out records that do not write the register file.
- Queues the rest in a first-word-fall-through FIFO and presents them to the consumer with valid/ready.
- Counts accepted records, and counts and flags records dropped on overflow, so the checker can tell real mismatches from buffering loss.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..64.
- FILTER_X0, 1, when 1, records with waddr == 0 are also discarded.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- sys_clk  input  1  single clock; all state updates on rising edge.
- sys_reset_n  input  1  synchronous, active-low reset.
- retire_valid  input  1  retire_record is meaningful this cycle.
- retire_record  input  70  [69] rf_en, [68:64] rf_waddr, [63:32] rf_wdata, [31:0] pc.
- trace_valid  output  1  FIFO head is valid.
- trace_ready  input  1  consumer takes the head this cycle.
- trace_record  output  70  FIFO head record; same field layout as retire_record.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky; set on the first dropped record.
- drop_cnt  output  DROP_W  records dropped due to full; saturates at all-ones.
- accept_cnt  output  32  records written to the FIFO; wraps modulo 2^32.

Behaviour:
- Reset (sys_reset_n low at a clock edge) clears:
  - read/write pointers and fifo_count;
  - trace_valid, fifo_full, overflow, drop_cnt, accept_cnt.
  - trace_record is don't-care while trace_valid = 0.
- Reset asserted mid-stream discards all queued entries and takes priority over push/pop in that cycle.
- Filter:
  - eligible = retire_valid & retire_record[69] & (FILTER_X0 == 0 | retire_record[68:64] != 0).
  - Non-eligible records have no effect on any state.
- pop = trace_valid & trace_ready.
- push = eligible & (!fifo_full | pop). When full, a simultaneous pop frees a slot and the push is accepted.
- drop = eligible & fifo_full & !pop. On drop:
  - overflow is set to 1 and stays set until reset;
  - drop_cnt increments unless already all-ones;
  - the FIFO is untouched.
- Storage update:
  - push writes mem[wr_ptr] and advances wr_ptr;
  - pop advances rd_ptr;
  - pointers wrap modulo DEPTH;
  - fifo_count changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- Output timing:
  - trace_valid = (fifo_count != 0); trace_record = mem[rd_ptr] (first-word fall-through).
  - A record pushed at edge N is visible at the output after that edge, with latency 1 cycle.
  - No same-cycle bypass: when empty, trace_valid is 0 in the push cycle.
- Order: records leave in exactly the order they were accepted, with no reordering and no duplication.
- Ready/valid rules:
  - trace_record is stable while trace_valid = 1 and trace_ready = 0.
  - trace_ready while trace_valid = 0 is ignored.
- accept_cnt increments by 1 on every push.

Test Plan:
- Reset, then push 3 eligible records with pc = 0x0, 0x4, 0x8, waddr = 1, 2, 3, with trace_ready = 1 → trace_valid rises 1 cycle after each push; records emerge in order; accept_cnt = 3; fifo_count returns to 0.
- Apply rf_en = 0 (pc = 0x10), rf_en = 1 with waddr = 0 (pc = 0x14), and retire_valid = 0 cycles → with FILTER_X0 = 1, nothing is queued and accept_cnt is unchanged.
- Hold trace_ready = 0 and push 10 eligible records with DEPTH = 8:
  - fifo_full = 1 after the 8th push; records 9–10 are dropped; overflow = 1; drop_cnt = 2;
  - draining yields the first 8 pc values in order.
- With the FIFO full, pulse trace_ready = 1 and push pc = 0x100 in the same cycle → head pops, 0x100 is accepted, fifo_count stays 8, drop_cnt unchanged.
- Hold trace_ready = 0 with 2 entries queued → trace_record is unchanged for 5 cycles; raise trace_ready → the entries pop one per cycle.
- Assert sys_reset_n = 0 for 1 cycle with 5 entries queued and a simultaneous push → next cycle: fifo_count = 0, trace_valid = 0, overflow = 0, drop_cnt = 0, accept_cnt = 0.
